// File: rtl/mem_pkg.sv
// Shared memory-access definitions: store size encodings, default address map
// and a small helper turning a size code into a byte count.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  localparam logic [31:0] DM_TOP_DEF = 32'h0000_2fff;
  localparam logic [31:0] DEV_LO_DEF = 32'h0000_7f00;
  localparam logic [31:0] DEV_HI_DEF = 32'h0000_7f23;
  localparam logic [31:0] RO_LO_DEF  = 32'h0000_7f08;
  localparam logic [31:0] RO_HI_DEF  = 32'h0000_7f0b;

  function automatic int unsigned size_bytes(input logic [1:0] sz);
    return 32'd1 << sz;
  endfunction

endpackage

// File: rtl/store_align.sv
// Combinational store alignment and address-error check.
// Ports:
//   valid     - store request present (gates ades)
//   addr      - byte address
//   size      - 00 byte, 01 half, 10 word, 11 dword
//   wdata     - right-aligned store data
//   ov        - address-calculation overflow
//   line_addr - addr with lane-offset bits cleared
//   byteen    - byte enables placed at the lane offset
//   data      - store data placed at the lane offset, unused bytes zero
//   ades      - store address exception
module store_align
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter logic [31:0] DM_TOP = DM_TOP_DEF,
  parameter logic [31:0] DEV_LO = DEV_LO_DEF,
  parameter logic [31:0] DEV_HI = DEV_HI_DEF,
  parameter logic [31:0] RO_LO  = RO_LO_DEF,
  parameter logic [31:0] RO_HI  = RO_HI_DEF
) (
  input  logic                valid,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [1:0]          size,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                ov,
  output logic [ADDR_W-1:0]   line_addr,
  output logic [DATA_W/8-1:0] byteen,
  output logic [DATA_W-1:0]   data,
  output logic                ades
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  localparam logic [ADDR_W-1:0] DmTop = ADDR_W'(DM_TOP);
  localparam logic [ADDR_W-1:0] DevLo = ADDR_W'(DEV_LO);
  localparam logic [ADDR_W-1:0] DevHi = ADDR_W'(DEV_HI);
  localparam logic [ADDR_W-1:0] RoLo  = ADDR_W'(RO_LO);
  localparam logic [ADDR_W-1:0] RoHi  = ADDR_W'(RO_HI);

  logic [OFF_W-1:0]  off;
  logic [NB-1:0]     ones;
  logic [DATA_W-1:0] keep;
  logic              misaligned, too_wide, in_dm, in_dev, in_ro;

  always_comb begin
    off       = addr[OFF_W-1:0];
    line_addr = addr & ~ADDR_W'(NB - 1);
    ones      = '0;
    keep      = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      ones[i]        = (i < size_bytes(size));
      keep[i*8 +: 8] = ones[i] ? wdata[i*8 +: 8] : 8'h00;
    end
    byteen = ones << off;
    data   = keep << {off, 3'b000};

    misaligned = (32'(off) & (size_bytes(size) - 32'd1)) != 32'd0;
    // A dword on a 32-bit bus does not fit in one lane.
    too_wide   = size_bytes(size) > NB;
    in_dm      = addr <= DmTop;
    in_dev     = (addr >= DevLo) && (addr <= DevHi);
    in_ro      = (addr >= RoLo) && (addr <= RoHi);

    ades = valid && (misaligned || too_wide || ov || (!in_dm && !in_dev) || in_ro ||
                     (in_dev && (size != SZ_W)));
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: FIFO of aligned stores between the pipeline and memory.
// Optional feature: define STORE_BUFFER_MERGE_EN to merge stores into the
// youngest (non-head) entry when its lane-aligned address matches.
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   req_*                 - store request handshake, exc_ades flags a faulting store
//   mem_*                 - head entry presented to memory, dequeued on valid && ready
//   chk_addr / chk_hit    - load probe against all pending entries
//   count / empty / full  - occupancy status
module store_buffer
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter logic [31:0] DM_TOP = DM_TOP_DEF,
  parameter logic [31:0] DEV_LO = DEV_LO_DEF,
  parameter logic [31:0] DEV_HI = DEV_HI_DEF,
  parameter logic [31:0] RO_LO  = RO_LO_DEF,
  parameter logic [31:0] RO_HI  = RO_HI_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [1:0]               req_size,
  input  logic [DATA_W-1:0]        req_wdata,
  input  logic                     req_ov,
  output logic                     exc_ades,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W/8-1:0]      mem_byteen,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [ADDR_W-1:0]        chk_addr,
  output logic                     chk_hit,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] a_addr;
  logic [NB-1:0]     a_be;
  logic [DATA_W-1:0] a_data;

  store_align #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DM_TOP (DM_TOP),
    .DEV_LO (DEV_LO),
    .DEV_HI (DEV_HI),
    .RO_LO  (RO_LO),
    .RO_HI  (RO_HI)
  ) u_align (
    .valid     (req_valid),
    .addr      (req_addr),
    .size      (req_size),
    .wdata     (req_wdata),
    .ov        (req_ov),
    .line_addr (a_addr),
    .byteen    (a_be),
    .data      (a_data),
    .ades      (exc_ades)
  );

  // Payload storage; left unreset since occupancy alone defines validity.
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [NB-1:0]     be_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic merge_possible, accept, do_push, do_pop;

`ifdef STORE_BUFFER_MERGE_EN
  logic [PTR_W-1:0]  young_idx;
  logic [DATA_W-1:0] byte_mask, merge_data;
  logic              do_merge;

  // With two or more entries the youngest is never the head.
  always_comb begin
    young_idx      = tail_q - PTR_W'(1);
    merge_possible = (count_q >= CNT_W'(2)) && (addr_q[young_idx] == a_addr);
    byte_mask      = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      byte_mask[b*8 +: 8] = {8{a_be[b]}};
    end
    merge_data = (data_q[young_idx] & ~byte_mask) | (a_data & byte_mask);
    do_merge   = accept && merge_possible;
  end
`else
  always_comb merge_possible = 1'b0;
`endif

  always_comb begin
    full      = (count_q == CNT_W'(DEPTH));
    empty     = (count_q == '0);
    req_ready = !full || merge_possible;
    mem_valid = !empty;
    accept    = req_valid && req_ready && !exc_ades;
    do_push   = accept && !merge_possible;
    do_pop    = mem_valid && mem_ready;

    head_d  = do_pop ? head_q + PTR_W'(1) : head_q;
    tail_d  = do_push ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);

    count      = count_q;
    mem_addr   = addr_q[head_q];
    mem_byteen = be_q[head_q];
    mem_wdata  = data_q[head_q];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_q[tail_q] <= a_addr;
      be_q[tail_q]   <= a_be;
      data_q[tail_q] <= a_data;
    end
`ifdef STORE_BUFFER_MERGE_EN
    if (do_merge) begin
      be_q[young_idx]   <= be_q[young_idx] | a_be;
      data_q[young_idx] <= merge_data;
    end
`endif
  end

  // An entry is occupied when its distance from the head is below the count.
  logic [ADDR_W-1:0] chk_line;
  logic [PTR_W-1:0]  rel;

  always_comb begin
    chk_hit  = 1'b0;
    rel      = '0;
    chk_line = chk_addr & ~ADDR_W'(NB - 1);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rel = PTR_W'(i) - head_q;
      if ((CNT_W'(rel) < count_q) && (addr_q[i] == chk_line)) begin
        chk_hit = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ov = 1'b0;
  logic        exc_ades;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_wdata;
  logic [31:0] chk_addr = '0;
  logic        chk_hit;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  store_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_wdata  (req_wdata),
    .req_ov     (req_ov),
    .exc_ades   (exc_ades),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_byteen (mem_byteen),
    .mem_wdata  (mem_wdata),
    .chk_addr   (chk_addr),
    .chk_hit    (chk_hit),
    .count      (count),
    .empty      (empty),
    .full       (full)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic        ov;
    logic        ades;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] maddr;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [1:0] s,
                       input logic [31:0] d, input logic o);
    req_valid = v;
    req_addr  = a;
    req_size  = s;
    req_wdata = d;
    req_ov    = o;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 2'b00, 32'h0, 1'b0);
  endtask

  // Inputs change only at the falling edge; checks happen 1 ns later.
  task automatic next();
    @(negedge clk);
  endtask

  // Reference rules, written straight from the address map.
  function automatic logic m_ades(input logic [31:0] a, input logic [1:0] s, input logic o);
    int unsigned n;
    int unsigned off;
    logic in_dm, in_dev, in_ro;
    n      = 1 << s;
    off    = a % 4;
    in_dm  = a <= 32'h2fff;
    in_dev = (a >= 32'h7f00) && (a <= 32'h7f23);
    in_ro  = (a >= 32'h7f08) && (a <= 32'h7f0b);
    return (off % n != 0) || (n > 4) || o || (!in_dm && !in_dev) || in_ro ||
           (in_dev && n != 4);
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] s);
    logic [3:0] r;
    int unsigned off;
    int unsigned n;
    off = a % 4;
    n   = 1 << s;
    r   = '0;
    for (int unsigned b = 0; b < 4; b++) r[b] = (b >= off) && (b < off + n);
    return r;
  endfunction

  function automatic logic [31:0] m_data(input logic [31:0] a, input logic [1:0] s,
                                         input logic [31:0] d);
    logic [31:0] r;
    logic [3:0]  be;
    int unsigned off;
    off = a % 4;
    be  = m_be(a, s);
    r   = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) r[b*8 +: 8] = d[(b - off)*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 4))
      0, 1:    return $urandom_range(0, 32'h40);
      2:       return 32'h7f00 + $urandom_range(0, 32'h2f);
      3:       return 32'h2ff0 + $urandom_range(0, 32'h20);
      default: return $urandom;
    endcase
  endfunction

  logic        m_merge_ok;
  logic        m_ready;
  logic        m_acc;
  logic        m_ex;
  logic        m_hit;
  ent_t        m_new;

  initial begin
    vecs[0]  = '{32'h0003, 2'b00, 32'h0000_00ab, 1'b0, 1'b0, 4'b1000, 32'hab00_0000, 32'h0000};
    vecs[1]  = '{32'h0001, 2'b01, 32'h0000_1234, 1'b0, 1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[2]  = '{32'h7f08, 2'b10, 32'h0000_0001, 1'b0, 1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[3]  = '{32'h7f10, 2'b10, 32'hdead_beef, 1'b0, 1'b0, 4'b1111, 32'hdead_beef, 32'h7f10};
    vecs[4]  = '{32'h0002, 2'b01, 32'h1234_abcd, 1'b0, 1'b0, 4'b1100, 32'habcd_0000, 32'h0000};
    vecs[5]  = '{32'h0000, 2'b11, 32'h0000_0000, 1'b0, 1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[6]  = '{32'h7f01, 2'b00, 32'h0000_0011, 1'b0, 1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[7]  = '{32'h3000, 2'b10, 32'h0000_0022, 1'b0, 1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[8]  = '{32'h2ffc, 2'b10, 32'h0102_0304, 1'b1, 1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[9]  = '{32'h2ffc, 2'b10, 32'h0102_0304, 1'b0, 1'b0, 4'b1111, 32'h0102_0304, 32'h2ffc};
    vecs[10] = '{32'h7f24, 2'b10, 32'h0000_0033, 1'b0, 1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[11] = '{32'h7f20, 2'b10, 32'hcafe_f00d, 1'b0, 1'b0, 4'b1111, 32'hcafe_f00d, 32'h7f20};
    vecs[12] = '{32'h2fff, 2'b00, 32'h0000_0055, 1'b0, 1'b0, 4'b1000, 32'h5500_0000, 32'h2ffc};
    vecs[13] = '{32'h7f0c, 2'b10, 32'h1111_1111, 1'b0, 1'b0, 4'b1111, 32'h1111_1111, 32'h7f0c};
    vecs[14] = '{32'h0001, 2'b00, 32'hffff_ff5a, 1'b0, 1'b0, 4'b0010, 32'h0000_5a00, 32'h0000};
    vecs[15] = '{32'h7f04, 2'b01, 32'h0000_4444, 1'b0, 1'b1, 4'b0000, 32'h0,         32'h0};

    // Reset state
    #12;
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    check("rst_chk_hit", 64'(chk_hit), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    next();
    reset = 1'b1;

    // Alignment / exception vectors, one store at a time into an empty buffer
    for (int i = 0; i < 16; i++) begin
      next();
      mem_ready = 1'b0;
      drive(1'b1, vecs[i].addr, vecs[i].size, vecs[i].wdata, vecs[i].ov);
      #1;
      check($sformatf("vec%0d_ades", i), 64'(exc_ades), 64'(vecs[i].ades));
      check($sformatf("vec%0d_nobypass", i), 64'(mem_valid), 64'd0);
      next();
      idle();
      #1;
      if (vecs[i].ades) begin
        check($sformatf("vec%0d_count", i), 64'(count), 64'd0);
      end else begin
        check($sformatf("vec%0d_count", i), 64'(count), 64'd1);
        check($sformatf("vec%0d_addr", i), 64'(mem_addr), 64'(vecs[i].maddr));
        check($sformatf("vec%0d_be", i), 64'(mem_byteen), 64'(vecs[i].be));
        check($sformatf("vec%0d_data", i), 64'(mem_wdata), 64'(vecs[i].data));
        mem_ready = 1'b1;
        next();
        mem_ready = 1'b0;
        #1;
        check($sformatf("vec%0d_drained", i), 64'(empty), 64'd1);
      end
    end

    // exc_ades low without req_valid even for a bad address
    next();
    drive(1'b0, 32'h0001, 2'b01, 32'h0, 1'b1);
    #1;
    check("ades_novalid", 64'(exc_ades), 64'd0);

    // Fill to full with the memory stalled; fifth store refused
    for (int i = 0; i < 5; i++) begin
      next();
      drive(1'b1, 32'h100 + 32'(4 * i), 2'b10, 32'h1000 + 32'(i), 1'b0);
      #1;
      check($sformatf("fill%0d_ready", i), 64'(req_ready), 64'(i < 4));
    end
    next();
    idle();
    #1;
    check("fill_count", 64'(count), 64'd4);
    check("fill_full", 64'(full), 64'd1);
    check("fill_ready", 64'(req_ready), 64'd0);
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_addr", i), 64'(mem_addr), 64'h100 + 64'(4 * i));
      check($sformatf("drain%0d_data", i), 64'(mem_wdata), 64'h1000 + 64'(i));
      next();
      #1;
    end
    check("drain_empty", 64'(empty), 64'd1);
    mem_ready = 1'b0;

    // Full buffer with simultaneous enqueue and dequeue: only the dequeue happens
    for (int i = 0; i < 4; i++) begin
      next();
      drive(1'b1, 32'h200 + 32'(4 * i), 2'b10, 32'h2000 + 32'(i), 1'b0);
    end
    next();
    drive(1'b1, 32'h300, 2'b10, 32'h3000, 1'b0);
    mem_ready = 1'b1;
    #1;
    check("sim_ready_full", 64'(req_ready), 64'd0);
    next();
    mem_ready = 1'b0;
    #1;
    check("sim_count3", 64'(count), 64'd3);
    check("sim_ready", 64'(req_ready), 64'd1);
    next();
    idle();
    #1;
    check("sim_count4", 64'(count), 64'd4);
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sim_order%0d", i), 64'(mem_addr),
            (i < 3) ? 64'h204 + 64'(4 * i) : 64'h300);
      next();
      #1;
    end
    check("sim_empty", 64'(empty), 64'd1);
    mem_ready = 1'b0;

`ifdef STORE_BUFFER_MERGE_EN
    // Merge into the youngest entry while stalled
    next();
    drive(1'b1, 32'h10, 2'b10, 32'h1111_2222, 1'b0);
    next();
    drive(1'b1, 32'h20, 2'b00, 32'h0000_00ab, 1'b0);
    next();
    drive(1'b1, 32'h21, 2'b00, 32'h0000_00cd, 1'b0);
    next();
    idle();
    chk_addr = 32'h22;
    #1;
    check("merge_count", 64'(count), 64'd2);
    check("merge_chk_hit", 64'(chk_hit), 64'd1);
    mem_ready = 1'b1;
    next();
    mem_ready = 1'b0;
    #1;
    check("merge_be", 64'(mem_byteen), 64'b0011);
    check("merge_byte1", 64'(mem_wdata[15:8]), 64'hcd);
    check("merge_data", 64'(mem_wdata), 64'h0000_cdab);
    mem_ready = 1'b1;
    next();
    mem_ready = 1'b0;
`endif

    // Asynchronous reset mid-handshake
    next();
    drive(1'b1, 32'h40, 2'b10, 32'h4040_4040, 1'b0);
    next();
    drive(1'b1, 32'h44, 2'b10, 32'h4444_4444, 1'b0);
    next();
    idle();
    chk_addr = 32'h40;
    #1;
    check("arst_pre_valid", 64'(mem_valid), 64'd1);
    check("arst_pre_hit", 64'(chk_hit), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_mem_valid", 64'(mem_valid), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_empty", 64'(empty), 64'd1);
    check("arst_ready", 64'(req_ready), 64'd1);
    check("arst_chk_hit", 64'(chk_hit), 64'd0);
    next();
    reset = 1'b1;

    // Randomized traffic against a queue model
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      next();
      drive(($urandom_range(0, 9) < 7), rand_addr(), 2'($urandom_range(0, 3)), $urandom,
            ($urandom_range(0, 15) == 0));
      mem_ready = ($urandom_range(0, 1) == 1);
      if (q.size() > 0 && $urandom_range(0, 1) == 1)
        chk_addr = q[$urandom_range(0, q.size() - 1)].addr + 32'($urandom_range(0, 3));
      else
        chk_addr = rand_addr();
      #1;

      m_merge_ok = 1'b0;
`ifdef STORE_BUFFER_MERGE_EN
      if (q.size() >= 2) m_merge_ok = (q[q.size() - 1].addr == (req_addr & ~32'h3));
`endif
      m_ready = (q.size() < DEPTH) || m_merge_ok;
      m_ex    = req_valid && m_ades(req_addr, req_size, req_ov);
      m_hit   = 1'b0;
      foreach (q[k]) if (q[k].addr == (chk_addr & ~32'h3)) m_hit = 1'b1;

      check("rnd_count", 64'(count), 64'(q.size()));
      check("rnd_mem_valid", 64'(mem_valid), 64'(q.size() > 0));
      check("rnd_full", 64'(full), 64'(q.size() == DEPTH));
      check("rnd_empty", 64'(empty), 64'(q.size() == 0));
      check("rnd_ready", 64'(req_ready), 64'(m_ready));
      check("rnd_ades", 64'(exc_ades), 64'(m_ex));
      check("rnd_chk_hit", 64'(chk_hit), 64'(m_hit));
      if (q.size() > 0) begin
        check("rnd_mem_addr", 64'(mem_addr), 64'(q[0].addr));
        check("rnd_mem_be", 64'(mem_byteen), 64'(q[0].be));
        check("rnd_mem_data", 64'(mem_wdata), 64'(q[0].data));
      end

      m_acc        = req_valid && m_ready && !m_ex;
      m_new.addr   = req_addr & ~32'h3;
      m_new.be     = m_be(req_addr, req_size);
      m_new.data   = m_data(req_addr, req_size, req_wdata);
      if (m_acc && m_merge_ok) begin
        for (int b = 0; b < 4; b++) begin
          if (m_new.be[b]) q[q.size() - 1].data[b*8 +: 8] = m_new.data[b*8 +: 8];
        end
        q[q.size() - 1].be = q[q.size() - 1].be | m_new.be;
      end
      if (q.size() > 0 && mem_ready) void'(q.pop_front());
      if (m_acc && !m_merge_ok) q.push_back(m_new);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
